// File: rtl/parity_fsm_pkg.sv
// Shared definitions for the serializer and the even/odd parity FSM it feeds.
// Holds the serializer state encoding and the default word width.
package parity_fsm_pkg;

  localparam int unsigned DATA_W_DEF = 8;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;

  typedef enum logic {
    IDLE  = ST_IDLE,
    SHIFT = ST_SHIFT
  } state_e;

endpackage

// File: rtl/bit_stream_serializer.sv
// Parallel-to-serial converter with valid/ready on both sides,
// frame boundary flags and a wrapping completed-word counter.
module bit_stream_serializer
  import parity_fsm_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               bit_out,
  output logic               bit_valid,
  input  logic               bit_ready,
  output logic               frame_start,
  output logic               frame_end,
  output logic [COUNT_W-1:0] frame_count
);

  localparam int unsigned CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [COUNT_W-1:0] frame_count_q, frame_count_d;

  logic busy;
  logic last_bit;
  logic valid_int;
  logic ready_int;
  logic word_acc;
  logic bit_xfer;
  logic head_bit;

  always_comb begin
    busy      = (state_q == SHIFT);
    last_bit  = (bit_cnt_q == LAST);
    valid_int = busy & ~rst;
    // Accepting on the last bit lets words stream without a bubble
    ready_int = ~rst & (~busy | (last_bit & bit_ready));
    word_acc  = in_valid & ready_int;
    bit_xfer  = valid_int & bit_ready;
    head_bit  = (MSB_FIRST != 0) ? shreg_q[DATA_W-1] : shreg_q[0];
  end

  always_comb begin
    state_d       = state_q;
    shreg_d       = shreg_q;
    bit_cnt_d     = bit_cnt_q;
    frame_count_d = frame_count_q;
    unique case (state_q)
      IDLE: begin
        if (word_acc) begin
          shreg_d   = in_data;
          bit_cnt_d = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (bit_xfer) begin
          if (!last_bit) begin
            shreg_d   = (MSB_FIRST != 0) ? (shreg_q << 1)
                                         : (shreg_q >> 1);
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end else begin
            frame_count_d = frame_count_q + COUNT_W'(1);
            if (word_acc) begin
              shreg_d   = in_data;
              bit_cnt_d = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      shreg_q       <= shreg_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    in_ready    = ready_int;
    bit_valid   = valid_int;
    bit_out     = valid_int & head_bit;
    frame_start = valid_int & (bit_cnt_q == '0);
    frame_end   = valid_int & last_bit;
    frame_count = rst ? '0 : frame_count_q;
  end

endmodule
